// File: rtl/pipeline_if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_if_fetch_pkg
// Shared definitions for the RV32IC instruction fetch stage:
//   NOP_INSTR          canonical bubble encoding (addi x0, x0, 0)
//   OPCODE_32BIT       low two bits of a halfword that starts a 32-bit instruction
//   BOOT_ADDR_DEFAULT  default reset PC
//   isCompressed()     classifies a head halfword as a 16-bit instruction
// ---------------------------------------------------------------------------
package pipeline_if_fetch_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [1:0]  OPCODE_32BIT      = 2'b11;
  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  // Any halfword whose two low bits are not 2'b11 is a complete RVC instruction.
  function automatic logic isCompressed(input logic [15:0] hw);
    return hw[1:0] != OPCODE_32BIT;
  endfunction

endpackage

// File: rtl/pipeline_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// Halfword circular buffer between instruction memory and the IF realigner.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   flush_i              empties the queue (wins over push/pop)
//   push1_i              write pushData_i[15:0] as one halfword
//   push2_i              write pushData_i[15:0] then pushData_i[31:16]
//   pushData_i[31:0]     data to write
//   pop1_i / pop2_i      remove one / two halfwords from the head
//   count_o              number of halfwords held
//   h0_o / h1_o          head halfword and the one behind it
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module if_fetch_queue
  import pipeline_if_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush_i,
  input  logic                     push1_i,
  input  logic                     push2_i,
  input  logic [31:0]              pushData_i,
  input  logic                     pop1_i,
  input  logic                     pop2_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [15:0]              h0_o,
  output logic [15:0]              h1_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [15:0]   store_q [DEPTH];
  logic [PW-1:0] rdPtr_q, wrPtr_q;
  logic [PW:0]   count_q;
  logic [PW-1:0] rdPtrPlus1, wrPtrPlus1;
  logic [PW:0]   pushCnt, popCnt;

  // Occupancy deltas and the neighbour slots used for two-halfword moves.
  always_comb begin
    rdPtrPlus1 = rdPtr_q + PW'(1);
    wrPtrPlus1 = wrPtr_q + PW'(1);
    pushCnt    = push2_i ? (PW+1)'(2) : (push1_i ? (PW+1)'(1) : '0);
    popCnt     = pop2_i  ? (PW+1)'(2) : (pop1_i  ? (PW+1)'(1) : '0);
  end

  // Pointer/occupancy bookkeeping plus the storage writes. The stage above
  // guarantees there is room for every push, so no full check is needed.
  always_ff @(posedge clk) begin
    if (!resetn || flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push1_i || push2_i) begin
        store_q[wrPtr_q] <= pushData_i[15:0];
      end
      if (push2_i) begin
        store_q[wrPtrPlus1] <= pushData_i[31:16];
      end
      wrPtr_q <= wrPtr_q + pushCnt[PW-1:0];
      rdPtr_q <= rdPtr_q + popCnt[PW-1:0];
      count_q <= count_q + pushCnt - popCnt;
    end
  end

  assign count_o = count_q;
  assign h0_o    = store_q[rdPtr_q];
  assign h1_o    = store_q[rdPtrPlus1];

endmodule

// File: rtl/pipeline_if_fetch.sv
// ---------------------------------------------------------------------------
// pipeline_if_fetch
// IF stage of the 5-stage RV32IC pipeline. Fetches aligned words into a
// halfword queue, realigns 16/32-bit instructions and hands one per cycle to
// ID through an output register. Redirects come from ID/EXE (OR'd upstream).
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   enable_i                    output register advance (0 = hazard stall)
//   redirect_i, redirect_pc_i   redirect request and target (bit 0 ignored)
//   imem_req_o, imem_addr_o     fetch request, word-aligned address
//   imem_gnt_i                  request accepted this cycle
//   imem_rvalid_i, imem_rdata_i response valid and data
//   instruction_f_o             instruction (RVC zero-extended)
//   pc_f_o, pc_plus4_f_o        instruction PC and next sequential PC
//   instr_valid_f_o             0 = bubble
// Optional (macro IF_PERF_CNT_EN):
//   perf_fetched_o              saturating count of valid loads
//   perf_bubble_o               saturating count of enabled bubble loads
// ---------------------------------------------------------------------------
module pipeline_if_fetch
  import pipeline_if_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT,
  parameter int unsigned FQ_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instruction_f_o,
  output logic [31:0] pc_f_o,
  output logic [31:0] pc_plus4_f_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_bubble_o,
`endif
  output logic        instr_valid_f_o
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  logic [CW-1:0] fqCount;
  logic [15:0]   fqH0, fqH1;

  logic          outstanding_q, outstanding_d;
  logic          discard_q, discard_d;
  logic          dropLow_q, dropLow_d;
  logic [31:0]   fetchAddr_q, fetchAddr_d;
  logic [31:0]   issuePc_q, issuePc_d;

  logic [31:0]   instr_q, pc_q, pcNext_q;
  logic          valid_q;

  logic          grant, respValid, respUse, push1, push2, pop1, pop2;
  logic          issueC, issue32, avail, advance;
  logic [31:0]   pushData, issueInstr, issueStep;

  // Request/response handshake and issue decode. A request needs room for a
  // full word (two halfwords) so pushes can never overflow the queue.
  always_comb begin
    imem_req_o = resetn && !outstanding_q && !redirect_i
                 && (fqCount <= CW'(FQ_DEPTH - 2));
    grant      = imem_req_o && imem_gnt_i;
    respValid  = imem_rvalid_i && outstanding_q;
    respUse    = respValid && !discard_q && !redirect_i;
    push1      = respUse && dropLow_q;
    push2      = respUse && !dropLow_q;
    pushData   = dropLow_q ? {16'h0000, imem_rdata_i[31:16]} : imem_rdata_i;

    issueC     = isCompressed(fqH0) && (fqCount != '0);
    issue32    = !isCompressed(fqH0) && (fqCount >= CW'(2));
    avail      = issueC || issue32;
    advance    = enable_i && !redirect_i;
    pop1       = advance && issueC;
    pop2       = advance && issue32;
    issueInstr = issueC ? {16'h0000, fqH0} : {fqH1, fqH0};
    issueStep  = issueC ? 32'd2 : 32'd4;
  end

  // Next-state for the fetch/issue bookkeeping. A redirect overrides every
  // other update; a stale in-flight response is marked for discard unless it
  // lands in the redirect cycle itself, where it is simply not pushed.
  always_comb begin
    fetchAddr_d   = fetchAddr_q;
    issuePc_d     = issuePc_q;
    dropLow_d     = dropLow_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (grant) begin
      outstanding_d = 1'b1;
    end else if (respValid) begin
      outstanding_d = 1'b0;
    end

    if (redirect_i && outstanding_q && !imem_rvalid_i) begin
      discard_d = 1'b1;
    end else if (respValid) begin
      discard_d = 1'b0;
    end

    if (redirect_i) begin
      fetchAddr_d = {redirect_pc_i[31:2], 2'b00};
      issuePc_d   = {redirect_pc_i[31:1], 1'b0};
      dropLow_d   = redirect_pc_i[1];
    end else begin
      if (grant) begin
        fetchAddr_d = fetchAddr_q + 32'd4;
      end
      if (push1) begin
        dropLow_d = 1'b0;
      end
      if (pop1 || pop2) begin
        issuePc_d = issuePc_q + issueStep;
      end
    end
  end

  // Fetch/issue state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetchAddr_q   <= {BOOT_ADDR[31:2], 2'b00};
      issuePc_q     <= BOOT_ADDR;
      dropLow_q     <= BOOT_ADDR[1];
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      fetchAddr_q   <= fetchAddr_d;
      issuePc_q     <= issuePc_d;
      dropLow_q     <= dropLow_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Output register towards ID. Bubbles carry a NOP with zeroed PCs.
  always_ff @(posedge clk) begin
    if (!resetn || redirect_i) begin
      instr_q  <= NOP_INSTR;
      pc_q     <= '0;
      pcNext_q <= '0;
      valid_q  <= 1'b0;
    end else if (enable_i) begin
      if (avail) begin
        instr_q  <= issueInstr;
        pc_q     <= issuePc_q;
        pcNext_q <= issuePc_q + issueStep;
        valid_q  <= 1'b1;
      end else begin
        instr_q  <= NOP_INSTR;
        pc_q     <= '0;
        pcNext_q <= '0;
        valid_q  <= 1'b0;
      end
    end
  end

  if_fetch_queue #(
    .DEPTH      (FQ_DEPTH)
  ) uQueue (
    .clk        (clk),
    .resetn     (resetn),
    .flush_i    (redirect_i),
    .push1_i    (push1),
    .push2_i    (push2),
    .pushData_i (pushData),
    .pop1_i     (pop1),
    .pop2_i     (pop2),
    .count_o    (fqCount),
    .h0_o       (fqH0),
    .h1_o       (fqH1)
  );

  assign imem_addr_o     = fetchAddr_q;
  assign instruction_f_o = instr_q;
  assign pc_f_o          = pc_q;
  assign pc_plus4_f_o    = pcNext_q;
  assign instr_valid_f_o = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perfFetched_q, perfBubble_q;

  // Saturating load counters; redirect cycles and stalls are not counted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perfFetched_q <= '0;
      perfBubble_q  <= '0;
    end else if (advance) begin
      if (avail) begin
        if (perfFetched_q != 32'hFFFF_FFFF) perfFetched_q <= perfFetched_q + 32'd1;
      end else begin
        if (perfBubble_q != 32'hFFFF_FFFF) perfBubble_q <= perfBubble_q + 32'd1;
      end
    end
  end

  assign perf_fetched_o = perfFetched_q;
  assign perf_bubble_o  = perfBubble_q;
`endif

endmodule

// File: tb/tb_pipeline_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_pipeline_if_fetch
// Drives pipeline_if_fetch with a memory responder (random grant and
// latency) and random enable/redirect/reset, and checks every loaded
// instruction against a program-order walk of the memory image.
// ---------------------------------------------------------------------------
module tb_pipeline_if_fetch;

  localparam int BUBBLE_LIMIT = 40;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] instruction_f_o, pc_f_o, pc_plus4_f_o;
  logic        instr_valid_f_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perfFetched, perfBubble;
`endif

  int checks = 0;
  int errors = 0;

  // Stimulus that was applied for the upcoming edge, read by the checker.
  logic        apResetn = 1'b0, apEnable = 1'b0, apRedirect = 1'b0;
  logic [31:0] apRpc = '0;

  // Memory responder state.
  int          gntPct = 100, latMin = 1, latMax = 1;
  logic        pendValid = 1'b0;
  logic [31:0] pendAddr = '0;
  int          pendWait = 0;
  int          grantCount = 0;
  logic [31:0] lastGrantAddr = '0;
  logic        expectNoReq = 1'b0;
  logic [31:0] memOverride [logic [31:0]];

  // Reference model state.
  logic [31:0] modelPc = '0;
  logic        heldValid = 1'b0;
  logic [31:0] heldInstr = 32'h13, heldPc = '0, heldPc4 = '0;
  int          bubbleRun = 0, validLoads = 0, bubbleLoads = 0;

  always #5 clk = ~clk;

  pipeline_if_fetch dut (
    .clk             (clk),
    .resetn          (resetn),
    .enable_i        (enable_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .instruction_f_o (instruction_f_o),
    .pc_f_o          (pc_f_o),
    .pc_plus4_f_o    (pc_plus4_f_o),
`ifdef IF_PERF_CNT_EN
    .perf_fetched_o  (perfFetched),
    .perf_bubble_o   (perfBubble),
`endif
    .instr_valid_f_o (instr_valid_f_o)
  );

  // Memory image: explicit words where a test needs them, a hash elsewhere
  // biased so both 16- and 32-bit encodings appear often.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    logic [31:0] w;
    if (memOverride.exists(addr)) return memOverride[addr];
    w = addr * 32'h9E37_79B1 + 32'h7F4A_7C15;
    w = w ^ (w >> 15);
    w = w * 32'h2C1B_3C6D;
    w = w ^ (w >> 13);
    if (w[8])  w[1:0]   = 2'b11;
    if (w[24]) w[17:16] = 2'b11;
    return w;
  endfunction

  function automatic logic [15:0] halfAt(input logic [31:0] pc);
    logic [31:0] w;
    w = memWord({pc[31:2], 2'b00});
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One cycle: drive controls and memory response at the falling edge, grant
  // once the request has settled, return after the checker has sampled.
  task automatic applyStimulus(input logic rstn, input logic en, input logic redir,
                               input logic [31:0] rpc);
    @(negedge clk);
    resetn = rstn; enable_i = en; redirect_i = redir; redirect_pc_i = rpc;
    apResetn = rstn; apEnable = en; apRedirect = redir; apRpc = rpc;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    imem_gnt_i    = 1'b0;
    if (!rstn) begin
      pendValid = 1'b0;
    end else if (pendValid) begin
      if (pendWait == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = memWord(pendAddr);
        pendValid     = 1'b0;
      end else begin
        pendWait--;
      end
    end
    #1;
    if (expectNoReq) checkOutput("stall_full_no_req", {31'b0, imem_req_o}, 32'd0);
    if (imem_req_o) begin
      checkOutput("req_addr_aligned", {30'b0, imem_addr_o[1:0]}, 32'd0);
      checkOutput("req_single_outstanding", {31'b0, pendValid || imem_rvalid_i}, 32'd0);
      if ($urandom_range(0, 99) < gntPct) begin
        imem_gnt_i    = 1'b1;
        pendValid     = 1'b1;
        pendAddr      = imem_addr_o;
        pendWait      = int'($urandom_range(latMin, latMax)) - 1;
        grantCount++;
        lastGrantAddr = imem_addr_o;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic waitValid(input string name, input int maxCycles);
    int n = 0;
    do begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end while (instr_valid_f_o !== 1'b1 && n < maxCycles);
    checkOutput({name, "_timeout"}, {31'b0, instr_valid_f_o}, 32'd1);
  endtask

  // Compare process: after each edge, work out what the output register must
  // hold from the applied controls and the program-order instruction stream.
  always @(posedge clk) begin
    logic [15:0] h0;
    logic [31:0] expInstr, expNext;
    #1;
    if (!apResetn) begin
      checkOutput("reset_instr", instruction_f_o, 32'h0000_0013);
      checkOutput("reset_pc", pc_f_o, 32'h0);
      checkOutput("reset_pc4", pc_plus4_f_o, 32'h0);
      checkOutput("reset_valid", {31'b0, instr_valid_f_o}, 32'd0);
      checkOutput("reset_req", {31'b0, imem_req_o}, 32'd0);
      modelPc = 32'h0; heldValid = 1'b0; heldInstr = 32'h13;
      bubbleRun = 0; validLoads = 0; bubbleLoads = 0;
    end else if (apRedirect) begin
      checkOutput("redirect_valid", {31'b0, instr_valid_f_o}, 32'd0);
      checkOutput("redirect_instr", instruction_f_o, 32'h0000_0013);
      modelPc = {apRpc[31:1], 1'b0};
      heldValid = 1'b0; heldInstr = 32'h13; bubbleRun = 0;
    end else if (apEnable) begin
      if (instr_valid_f_o === 1'b1) begin
        h0 = halfAt(modelPc);
        if (h0[1:0] != 2'b11) begin
          expInstr = {16'h0, h0};
          expNext  = modelPc + 32'd2;
        end else begin
          expInstr = {halfAt(modelPc + 32'd2), h0};
          expNext  = modelPc + 32'd4;
        end
        checkOutput("issue_instr", instruction_f_o, expInstr);
        checkOutput("issue_pc", pc_f_o, modelPc);
        checkOutput("issue_pc4", pc_plus4_f_o, expNext);
        heldValid = 1'b1; heldInstr = expInstr; heldPc = modelPc; heldPc4 = expNext;
        modelPc = expNext;
        bubbleRun = 0;
        validLoads++;
      end else begin
        checkOutput("bubble_valid", {31'b0, instr_valid_f_o}, 32'd0);
        checkOutput("bubble_instr", instruction_f_o, 32'h0000_0013);
        bubbleRun++;
        bubbleLoads++;
        checkOutput("bubble_run_bound", {31'b0, bubbleRun > BUBBLE_LIMIT}, 32'd0);
        heldValid = 1'b0; heldInstr = 32'h13;
      end
    end else begin
      checkOutput("hold_valid", {31'b0, instr_valid_f_o}, {31'b0, heldValid});
      checkOutput("hold_instr", instruction_f_o, heldInstr);
      if (heldValid) begin
        checkOutput("hold_pc", pc_f_o, heldPc);
        checkOutput("hold_pc4", pc_plus4_f_o, heldPc4);
      end
    end
  end

  initial begin
    int startGrants;
    int n;
    logic [31:0] rpc;

    // Reset from BOOT_ADDR = 0, single-word instruction with 1-cycle latency.
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    memOverride[32'h0] = 32'h00A0_0093;
    waitValid("first_fetch", 20);
    checkOutput("first_pc", pc_f_o, 32'h0);
    checkOutput("first_instr", instruction_f_o, 32'h00A0_0093);
    checkOutput("first_pc4", pc_plus4_f_o, 32'h4);

    // Compressed instruction followed by a 32-bit one straddling words.
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    memOverride.delete();
    memOverride[32'h0] = 32'h0093_4501;
    memOverride[32'h4] = 32'h0001_0513;
    waitValid("rvc_fetch", 20);
    checkOutput("rvc_instr", instruction_f_o, 32'h0000_4501);
    checkOutput("rvc_pc", pc_f_o, 32'h0);
    checkOutput("rvc_pc4", pc_plus4_f_o, 32'h2);
    waitValid("straddle_fetch", 20);
    checkOutput("straddle_instr", instruction_f_o, 32'h0513_0093);
    checkOutput("straddle_pc", pc_f_o, 32'h2);
    checkOutput("straddle_pc4", pc_plus4_f_o, 32'h6);

    // Redirect to 0x106 while a 3-cycle response is still in flight.
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    memOverride.delete();
    memOverride[32'h104] = 32'h4505_1234;
    latMin = 3; latMax = 3;
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end while (!(pendValid && pendWait >= 1) && n < 10);
    checkOutput("redirect_setup_timeout", {31'b0, pendValid}, 32'd1);
    startGrants = grantCount;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h106);
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end while (grantCount == startGrants && n < 20);
    checkOutput("redirect_first_addr", lastGrantAddr, 32'h104);
    waitValid("redirect_fetch", 20);
    checkOutput("redirect_new_instr", instruction_f_o, 32'h0000_4505);
    checkOutput("redirect_new_pc", pc_f_o, 32'h106);
    checkOutput("redirect_new_pc4", pc_plus4_f_o, 32'h108);

    // Long stall: the queue fills and requests stop; nothing lost afterwards.
    latMin = 1; latMax = 1;
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    expectNoReq = 1'b1;
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    expectNoReq = 1'b0;
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect together with a stall still takes the redirect.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
    checkOutput("stall_redirect_valid", {31'b0, instr_valid_f_o}, 32'd0);
    checkOutput("stall_redirect_instr", instruction_f_o, 32'h0000_0013);
    waitValid("stall_redirect_fetch", 20);
    checkOutput("stall_redirect_pc", pc_f_o, 32'h40);

    // Random traffic, including wrap-around targets and a mid-run reset.
    gntPct = 70; latMin = 1; latMax = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        rpc = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
      else
        rpc = $urandom & 32'h0000_03FF;
      applyStimulus(i != 1500, $urandom_range(0, 99) < 80,
                    $urandom_range(0, 99) < 3, rpc);
    end

`ifdef IF_PERF_CNT_EN
    checkOutput("perf_fetched", perfFetched, validLoads);
    checkOutput("perf_bubble", perfBubble, bubbleLoads);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
